dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer for the single-port data memory controller. It sits between two requesters and the memory controller: port 0 is the memory-access pipeline stage and port 1 is the debug/loader port. It grants one requester at a time and drives address, write data, store strobe and access width for exactly one transaction. It then returns the read data with a one-cycle acknowledge.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstd  in  1  reset, asynchronous, active-low.
- req0 / req1  in  1  request from port 0 / port 1; held high until the matching ack.
- we0 / we1  in  1  1 = store, 0 = load.
- addr0 / addr1  in  ADDR_W  byte address.
- wdata0 / wdata1  in  DATA_W  store data.
- width0 / width1  in  2  access width: 0 byte, 1 half, 2 word; 3 is treated as word.
- uns0 / uns1  in  1  unsigned-load flag.
- ack0 / ack1  out  1  one-cycle transaction-complete pulse.
- rdata0 / rdata1  out  DATA_W  load data; valid only while the matching ack is high, 0 otherwise.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  store strobe; only ever high together with mem_en.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched store data.
- mem_width  out  2  latched width.
- mem_uns  out  1  latched unsigned flag.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en.
- busy  out  1  high in ISSUE and RESP.

## Operation
- The FSM has three states: IDLE, ISSUE, RESP.
- **IDLE**
  - If req0 or req1 is high, select a winner, capture its we/addr/wdata/width/uns into registers, record the winner in `gnt`, and go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - mem_en = 1.
  - mem_we = latched we.
  - mem_* outputs come from the latched registers, never from live inputs.
  - Always go to RESP.
- **RESP**
  - ack[gnt] = 1.
  - For a load, rdata[gnt] = mem_rdata. For a store, rdata[gnt] = 0.
  - Always go to IDLE.
- Arbitration when only one request is high: that port wins.
- Arbitration when both requests are high is set by the Configuration section.
- Inputs change while in ISSUE or RESP: ignored, because the registers are already latched.
- A requester must deassert req in the cycle after its ack. Otherwise IDLE treats the held req as a new request.
- Width 3 is stored as 2 on mem_width.
- No address decode is done here; all addresses are forwarded to the memory controller.

## Timing
- Reset values, applied asynchronously on rstd = 0:
  - state = IDLE, gnt = 0, last_gnt = 1.
  - All latched registers = 0.
  - mem_en, mem_we, ack0, ack1, busy = 0.
  - rdata0, rdata1, mem_addr, mem_wdata = 0; mem_width = 0; mem_uns = 0.
- Latency: req sampled high in IDLE at cycle N → ISSUE (mem_en) in N+1 → ack in N+2.
- Throughput: at most one transaction per 3 cycles.
- Back-to-back pending request: the next grant is decided in the IDLE cycle N+3.
- Reset asserted in ISSUE or RESP: the FSM drops to IDLE immediately, no ack is issued, and the transaction is lost. The requester must reissue after reset.
- Simultaneous req0 and req1 arriving in the same IDLE cycle: exactly one grant; the loser stays pending and is served in the next IDLE cycle.
- acks are mutually exclusive and never high in two consecutive cycles.

## Configuration
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- **Defined:** round-robin.
  - On a tie, the port not equal to last_gnt wins.
  - last_gnt updates on every grant.
  - With reset last_gnt = 1, port 0 wins the first tie.
- **Undefined:** fixed priority.
  - Port 0 always wins a tie.
  - last_gnt register is not present.
  - Port 1 can starve under continuous port-0 traffic; this is accepted.

## Test plan
- **Port 0 load:** after reset, req0 = 1, we0 = 0, addr0 = 0x0000_0100, width0 = 2, mem_rdata = 0xDEAD_BEEF when sampled.
  - Expect mem_en = 1 and mem_addr = 0x100 at N+1.
  - Expect ack0 = 1 and rdata0 = 0xDEADBEEF at N+2.
  - Expect ack1 = 0 throughout.
- **Port 1 store:** req1 = 1, we1 = 1, addr1 = 0x0000_0204, wdata1 = 0x1234_5678, width1 = 0.
  - Expect mem_we = 1, mem_wdata = 0x12345678 and mem_width = 0 in ISSUE.
  - Expect ack1 at N+2 with rdata1 = 0.
- **Tie, both held continuously:**
  - With the macro defined, expect grants in the order 0, 1, 0, 1 with acks at cycles 2, 5, 8, 11.
  - Without the macro, expect grants 0, 0, 0, 0.
- **Input change after grant:** change addr0 from 0x100 to 0x200 during ISSUE. Expect mem_addr to stay at 0x100.
- **Reset mid-transaction:** pull rstd low during RESP. Expect ack0, mem_en and busy to go low immediately and state = IDLE. After release, a held req0 produces an ack 2 cycles after the first IDLE sample.
- **Width 3:** req0 with width0 = 3. Expect mem_width = 2.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter/sequencer in front of the single-port data memory controller
//
// Purpose:
//   Grants one of two requesters (port 0 = memory-access pipeline stage,
//   port 1 = debug/loader) at a time, latches its request fields, issues a
//   single memory access and returns the result with a one-cycle ack.
//   Sequence: IDLE (grant + latch) -> ISSUE (mem_en) -> RESP (ack).
//
// Configuration macro:
//   DMEM_ARB_ROUND_ROBIN_EN  defined   : round-robin tie break via last_gnt
//                            undefined : fixed priority, port 0 wins ties
//
// Ports:
//   clk, rstd                      clock, asynchronous active-low reset
//   req0/1, we0/1, addr0/1,        requester side; req held until its ack
//   wdata0/1, width0/1, uns0/1
//   ack0/1, rdata0/1               one-cycle completion pulse and load data
//   mem_en, mem_we, mem_addr,      memory controller side, driven from the
//   mem_wdata, mem_width, mem_uns  latched request registers
//   mem_rdata                      memory read data, valid the cycle after mem_en
//   busy                           high in ISSUE and RESP

module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [1:0]        width0,
    input  logic [1:0]        width1,
    input  logic              uns0,
    input  logic              uns1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_width,
    output logic              mem_uns,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state_q;
    logic                gnt_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [1:0]          width_q;
    logic                uns_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic                ack0_q;
    logic                ack1_q;
    logic                busy_q;

    logic                tie_win;
    logic                gnt_d;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [1:0]          width_d;
    logic                uns_d;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic                last_gnt_q;
    // On a tie the port that was not served last goes first.
    assign tie_win = ~last_gnt_q;
`else
    assign tie_win = 1'b0;
`endif

    // With a single request the requester wins; req1 alone selects port 1.
    assign gnt_d   = (req0 && req1) ? tie_win : req1;
    assign we_d    = gnt_d ? we1    : we0;
    assign addr_d  = gnt_d ? addr1  : addr0;
    assign wdata_d = gnt_d ? wdata1 : wdata0;
    // Width 3 is an alias for word, normalised before it reaches the controller.
    assign width_d = ((gnt_d ? width1 : width0) == 2'd3) ? 2'd2 : (gnt_d ? width1 : width0);
    assign uns_d   = gnt_d ? uns1   : uns0;

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            width_q    <= 2'd0;
            uns_q      <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_gnt_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        state_q    <= ISSUE;
                        gnt_q      <= gnt_d;
                        we_q       <= we_d;
                        addr_q     <= addr_d;
                        wdata_q    <= wdata_d;
                        width_q    <= width_d;
                        uns_q      <= uns_d;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= we_d;
                        busy_q     <= 1'b1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                        last_gnt_q <= gnt_d;
`endif
                    end
                end
                ISSUE: begin
                    state_q  <= RESP;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    ack0_q   <= ~gnt_q;
                    ack1_q   <= gnt_q;
                end
                RESP: begin
                    state_q <= IDLE;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    ack0_q   <= 1'b0;
                    ack1_q   <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_width = width_q;
    assign mem_uns   = uns_q;
    assign busy      = busy_q;

    // mem_rdata only becomes valid in RESP, so load data is steered through
    // combinationally while the ack is up; stores return zero.
    assign rdata0 = (ack0_q && !we_q) ? mem_rdata : '0;
    assign rdata1 = (ack1_q && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rstd;
    logic        req0, req1, we0, we1, uns0, uns1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  width0, width1;
    logic        ack0, ack1, mem_en, mem_we, mem_uns, busy;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_width;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic prev_ack = 1'b0;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
        logic        uns;
        logic [31:0] mrd;
        logic [1:0]  exp_width;
        logic [31:0] exp_rdata;
    } vec_t;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rstd(rstd),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .width0(width0), .width1(width1), .uns0(uns0), .uns1(uns1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_width(mem_width), .mem_uns(mem_uns),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard and protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rstd) begin
            check("ack_exclusive", {31'd0, ack0 && ack1}, 32'd0);
            check("ack_not_consecutive", {31'd0, (ack0 || ack1) && prev_ack}, 32'd0);
            check("we_implies_en", {31'd0, mem_we && !mem_en}, 32'd0);
            if (ack0 || ack1) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_ack", 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    check("sb_port", {31'd0, ack1}, {31'd0, e.port});
                    check("sb_rdata", e.port ? rdata1 : rdata0, e.rdata);
                    check("sb_other_rdata", e.port ? rdata0 : rdata1, 32'd0);
                end
            end else begin
                check("rdata_idle_zero", rdata0 | rdata1, 32'd0);
            end
        end
        prev_ack <= ack0 || ack1;
    end

    task automatic drive_port(input logic p, input logic rq, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] wd, input logic u);
        if (!p) begin
            req0 = rq; we0 = w; addr0 = a; wdata0 = d; width0 = wd; uns0 = u;
        end else begin
            req1 = rq; we1 = w; addr1 = a; wdata1 = d; width1 = wd; uns1 = u;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstd = 1'b0;
        #3;
        rstd = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string sfx;
        sfx = $sformatf("[%0d]", idx);
        @(posedge clk); #1;
        drive_port(v.port, 1'b1, v.we, v.addr, v.wdata, v.width, v.uns);
        mem_rdata = v.mrd;
        sb_q.push_back('{port: v.port, rdata: v.exp_rdata});
        @(negedge clk);
        check({"idle_en", sfx}, {31'd0, mem_en}, 32'd0);
        check({"idle_busy", sfx}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({"issue_en", sfx}, {31'd0, mem_en}, 32'd1);
        check({"issue_we", sfx}, {31'd0, mem_we}, {31'd0, v.we});
        check({"issue_addr", sfx}, mem_addr, v.addr);
        check({"issue_wdata", sfx}, mem_wdata, v.wdata);
        check({"issue_width", sfx}, {30'd0, mem_width}, {30'd0, v.exp_width});
        check({"issue_uns", sfx}, {31'd0, mem_uns}, {31'd0, v.uns});
        check({"issue_busy", sfx}, {31'd0, busy}, 32'd1);
        // Scramble the live inputs; the latched transaction must not move.
        drive_port(v.port, 1'b1, ~v.we, v.addr ^ 32'h300, ~v.wdata, ~v.width, ~v.uns);
        @(negedge clk);
        check({"resp_en", sfx}, {31'd0, mem_en}, 32'd0);
        check({"resp_busy", sfx}, {31'd0, busy}, 32'd1);
        check({"resp_addr_held", sfx}, mem_addr, v.addr);
        check({"resp_ack_port", sfx}, {30'd0, ack1, ack0}, v.port ? 32'd2 : 32'd1);
        drive_port(v.port, 1'b0, v.we, v.addr, v.wdata, v.width, v.uns);
        @(negedge clk);
        check({"post_busy", sfx}, {31'd0, busy}, 32'd0);
    endtask

    vec_t vecs[6];
    int   ack_cyc[$];
    int   t0;
    int   ack_at;
    logic exp_tie[4];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         2'd2, 1'b0, 32'hDEAD_BEEF, 2'd2, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0204, 32'h1234_5678, 2'd0, 1'b0, 32'h5555_AAAA, 2'd0, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         2'd3, 1'b1, 32'h0000_00FF, 2'd2, 32'h0000_00FF};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_03FE, 32'h0,         2'd1, 1'b1, 32'h0000_BEEF, 2'd1, 32'h0000_BEEF};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_CAFE, 2'd1, 1'b0, 32'hFFFF_FFFF, 2'd1, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         2'd3, 1'b0, 32'h89AB_CDEF, 2'd2, 32'h89AB_CDEF};
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        exp_tie = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_tie = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

        rstd = 1'b0; mem_rdata = 32'h0;
        drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
        drive_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
        #12;
        check("rst_ctrl", {26'd0, ack0, ack1, mem_en, mem_we, busy, mem_uns}, 32'd0);
        check("rst_rdata", rdata0 | rdata1, 32'd0);
        check("rst_mem_bus", mem_addr | mem_wdata | {30'd0, mem_width}, 32'd0);
        @(posedge clk); #1;
        rstd = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Tie: both ports held continuously from a fresh reset.
        do_reset();
        @(posedge clk); #1;
        drive_port(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 2'd2, 1'b0);
        drive_port(1'b1, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 2'd2, 1'b0);
        mem_rdata = 32'h0BAD_F00D;
        for (int k = 0; k < 4; k++) sb_q.push_back('{port: exp_tie[k], rdata: 32'h0BAD_F00D});
        t0 = cyc;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ack0 || ack1) ack_cyc.push_back(cyc - t0);
        end
        req0 = 1'b0; req1 = 1'b0;
        check("tie_ack_count", ack_cyc.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < ack_cyc.size()) check($sformatf("tie_ack_cycle[%0d]", k), ack_cyc[k], 3 * k + 2);
        end
        repeat (2) @(negedge clk);

        // Reset asserted during RESP: transaction dropped, held req reissues.
        @(posedge clk); #1;
        drive_port(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 2'd2, 1'b0);
        mem_rdata = 32'h1357_9BDF;
        @(posedge clk);
        @(posedge clk); #1;
        check("rst_mid_ack_before", {31'd0, ack0}, 32'd1);
        #1 rstd = 1'b0;
        #1;
        check("rst_mid_ack", {31'd0, ack0}, 32'd0);
        check("rst_mid_en_busy", {30'd0, mem_en, busy}, 32'd0);
        check("rst_mid_rdata", rdata0, 32'd0);
        check("rst_mid_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        rstd = 1'b1;
        sb_q.push_back('{port: 1'b0, rdata: 32'h1357_9BDF});
        t0 = cyc;
        ack_at = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack0 && ack_at < 0) begin
                ack_at = cyc - t0;
                req0 = 1'b0;
            end
        end
        req0 = 1'b0;
        check("rst_reissue_latency", ack_at, 32'd2);

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
